// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: size codes, FSM encoding,
// latency limit and the store-side lane helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int MAX_READ_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // The reserved size code behaves as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// MEM-stage request/response and bus-side signals of the data-memory bridge.
// slave = the bridge itself, master = the pipeline plus bus fabric around it.
interface dmem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2
);

  logic                     req_valid;
  logic                     req_wen;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [ADDR_W-1:0]        req_addr;
  logic [DATA_W-1:0]        req_wdata;

  logic                     stall;
  logic                     rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     misalign_err;

  logic [ADDR_W-1:0]        bus_addr;
  logic [NUM_CH-1:0]        bus_ch_sel;
  logic                     bus_wen;
  logic [1:0]               bus_mask;
  logic [3:0]               bus_be;
  logic [DATA_W-1:0]        bus_wdata;
  logic [NUM_CH*DATA_W-1:0] bus_rdata;

  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    output stall, rsp_valid, rsp_rdata, misalign_err,
    output bus_addr, bus_ch_sel, bus_wen, bus_mask, bus_be, bus_wdata,
    input  bus_rdata
  );

  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    input  stall, rsp_valid, rsp_rdata, misalign_err,
    input  bus_addr, bus_ch_sel, bus_wen, bus_mask, bus_be, bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/dmem_bridge_load_align.sv
// Load alignment: picks the byte/half at the byte offset and sign- or
// zero-extends it; words pass straight through.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = 32'h0000_0000;
    case (offset)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (size)
      SZ_BYTE: begin
        if (is_unsigned) begin
          data = {24'h00_0000, byte_s};
        end else begin
          data = {{24{byte_s[7]}}, byte_s};
        end
      end
      SZ_HALF: begin
        if (is_unsigned) begin
          data = {16'h0000, half_s};
        end else begin
          data = {{16{half_s[15]}}, half_s};
        end
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge between the MEM stage and a NUM_CH-channel bus.
// Optional DMEM_RSP_REG_EN adds one register stage on rsp_valid/rsp_rdata.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int NUM_CH    = 2,
  parameter int CH_SEL_LO = 28
) (
  input logic       clk,
  input logic       rst,
  dmem_bridge_if.slave dmem
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam bit LOAD_WAITS = (READ_LAT != 0);
  // Issue cycle plus (READ_LAT-1) WAIT cycles; the counter holds the remaining WAIT cycles minus one.
  localparam logic [1:0] WAIT_INIT = (READ_LAT >= 2) ? 2'(READ_LAT - 2) : 2'b00;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_bridge: DATA_W must be 32");
  end
  if (READ_LAT < 0 || READ_LAT > MAX_READ_LAT) begin : g_bad_lat
    $error("dmem_bridge: READ_LAT out of range");
  end
  if (NUM_CH < 1 || NUM_CH > 8 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_ch
    $error("dmem_bridge: NUM_CH must be a power of 2 in 1..8");
  end

  state_t            state_r;
  logic [1:0]        cnt_r;
  logic [CH_W-1:0]   ch_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        off_r;
  logic [1:0]        size_r;
  logic              uns_r;

  logic [CH_W-1:0]   ch_idx_s;
  logic [CH_W-1:0]   rd_ch_s;
  logic [ADDR_W-1:0] word_addr_s;
  logic [NUM_CH-1:0] req_sel_s;
  logic [NUM_CH-1:0] cap_sel_s;
  logic              pend_s;
  logic              accept_s;
  logic              mis_s;
  logic [DATA_W-1:0] ch_rdata_a [2**CH_W];
  logic [DATA_W-1:0] ch_rdata_s;
  logic [1:0]        al_off_s;
  logic [1:0]        al_size_s;
  logic              al_uns_s;
  logic [31:0]       al_data_s;

  logic              stall_raw_s;
  logic              rsp_raw_v_s;
  logic [DATA_W-1:0] rsp_raw_d_s;
  logic              mis_err_s;
  logic [ADDR_W-1:0] bus_addr_s;
  logic [NUM_CH-1:0] bus_sel_s;
  logic              bus_wen_s;
  logic [1:0]        bus_mask_s;
  logic [3:0]        bus_be_s;
  logic [DATA_W-1:0] bus_wdata_s;

  if (NUM_CH > 1) begin : g_ch_dec
    assign ch_idx_s = dmem.req_addr[CH_SEL_LO +: CH_W];
  end else begin : g_ch_one
    assign ch_idx_s = '0;
  end

  for (genvar k = 0; k < 2**CH_W; k++) begin : g_rd
    if (k < NUM_CH) begin : g_live
      assign ch_rdata_a[k] = dmem.bus_rdata[k*DATA_W +: DATA_W];
    end else begin : g_pad
      assign ch_rdata_a[k] = '0;
    end
  end

  assign word_addr_s = {dmem.req_addr[ADDR_W-1:2], 2'b00};
  assign req_sel_s   = NUM_CH'(1'b1) << ch_idx_s;
  assign cap_sel_s   = NUM_CH'(1'b1) << ch_r;
  assign accept_s    = dmem.req_valid & (state_r == ST_IDLE) & ~pend_s;
  assign mis_s       = is_misaligned(dmem.req_size, dmem.req_addr[1:0]);

  // In RESP the aligner works on captured fields; otherwise on the live request (zero-latency path).
  always_comb begin
    if (state_r == ST_RESP) begin
      rd_ch_s   = ch_r;
      al_off_s  = off_r;
      al_size_s = size_r;
      al_uns_s  = uns_r;
    end else begin
      rd_ch_s   = ch_idx_s;
      al_off_s  = dmem.req_addr[1:0];
      al_size_s = dmem.req_size;
      al_uns_s  = dmem.req_unsigned;
    end
    ch_rdata_s = ch_rdata_a[rd_ch_s];
  end

  load_align u_align (
    .rdata       (ch_rdata_s),
    .offset      (al_off_s),
    .size        (al_size_s),
    .is_unsigned (al_uns_s),
    .data        (al_data_s)
  );

  // Bus strobes, stall and raw response, all forced low while reset is asserted.
  always_comb begin
    stall_raw_s = 1'b0;
    rsp_raw_v_s = 1'b0;
    rsp_raw_d_s = '0;
    mis_err_s   = 1'b0;
    bus_addr_s  = '0;
    bus_sel_s   = '0;
    bus_wen_s   = 1'b0;
    bus_mask_s  = 2'b00;
    bus_be_s    = 4'b0000;
    bus_wdata_s = '0;
    if (rst) begin
      stall_raw_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!accept_s) begin
            stall_raw_s = 1'b0;
          end else if (mis_s) begin
            mis_err_s   = 1'b1;
            rsp_raw_v_s = ~dmem.req_wen;
          end else begin
            bus_addr_s  = word_addr_s;
            bus_sel_s   = req_sel_s;
            bus_wen_s   = dmem.req_wen;
            bus_mask_s  = dmem.req_size;
            bus_be_s    = byte_enables(dmem.req_size, dmem.req_addr[1:0]);
            bus_wdata_s = steer_wdata(dmem.req_size, dmem.req_wdata);
            if (dmem.req_wen) begin
              stall_raw_s = 1'b0;
            end else if (LOAD_WAITS) begin
              stall_raw_s = 1'b1;
            end else begin
              rsp_raw_v_s = 1'b1;
              rsp_raw_d_s = al_data_s;
            end
          end
        end
        ST_WAIT: begin
          bus_addr_s  = addr_r;
          bus_sel_s   = cap_sel_s;
          bus_mask_s  = size_r;
          bus_be_s    = byte_enables(size_r, off_r);
          stall_raw_s = 1'b1;
        end
        ST_RESP: begin
          bus_addr_s  = addr_r;
          bus_sel_s   = cap_sel_s;
          bus_mask_s  = size_r;
          bus_be_s    = byte_enables(size_r, off_r);
          rsp_raw_v_s = 1'b1;
          rsp_raw_d_s = al_data_s;
        end
        default: begin
          stall_raw_s = 1'b0;
        end
      endcase
    end
  end

  // Load sequencing: capture the access at issue and count down the bus read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'b00;
      ch_r    <= '0;
      addr_r  <= '0;
      off_r   <= 2'b00;
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && !mis_s && !dmem.req_wen && LOAD_WAITS) begin
            ch_r    <= ch_idx_s;
            addr_r  <= word_addr_s;
            off_r   <= dmem.req_addr[1:0];
            size_r  <= dmem.req_size;
            uns_r   <= dmem.req_unsigned;
            cnt_r   <= WAIT_INIT;
            state_r <= (READ_LAT == 1) ? ST_RESP : ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 2'b00) begin
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 2'b01;
          end
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_RSP_REG_EN
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;

  // The registered response also blocks re-issue of the still-held request for one cycle.
  assign pend_s = rsp_valid_r;

  // Response register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
    end else begin
      rsp_valid_r <= rsp_raw_v_s;
      rsp_rdata_r <= rsp_raw_d_s;
    end
  end

  assign dmem.stall     = stall_raw_s | rsp_raw_v_s;
  assign dmem.rsp_valid = rsp_valid_r & ~rst;
  assign dmem.rsp_rdata = rst ? '0 : rsp_rdata_r;
`else
  assign pend_s         = 1'b0;
  assign dmem.stall     = stall_raw_s;
  assign dmem.rsp_valid = rsp_raw_v_s;
  assign dmem.rsp_rdata = rsp_raw_d_s;
`endif

  assign dmem.misalign_err = mis_err_s;
  assign dmem.bus_addr     = bus_addr_s;
  assign dmem.bus_ch_sel   = bus_sel_s;
  assign dmem.bus_wen      = bus_wen_s;
  assign dmem.bus_mask     = bus_mask_s;
  assign dmem.bus_be       = bus_be_s;
  assign dmem.bus_wdata    = bus_wdata_s;

endmodule
